// File: rtl/keypad_debounce_edge.sv
// Keypad front end: normalise, 2-FF sync, counter debounce, rising-edge one-hot press pulse with lockout.
// Latency: raw change -> key_level after 2+DB_CYCLES edges, key_pulse one edge later; no backpressure (free-running pulses).
module keypad_debounce_edge #(
    parameter int WIDTH         = 11,
    parameter int DB_CYCLES     = 500000,
    parameter int CNT_W         = 19,
    parameter bit IN_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_pulse,
    output logic             multi_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stb_q, stb_d;
    logic [WIDTH-1:0] stb_dly_q, stb_dly_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] key_pulse_q, key_pulse_d;
    logic             multi_press_q, multi_press_d;

    // Everything downstream works on active-high "pressed", so reset 0 means released.
    assign norm = IN_ACTIVE_LOW ? ~key_raw : key_raw;

    always_comb begin
        sync1_d   = norm;
        sync2_d   = sync1_q;
        stb_d     = stb_q;
        stb_dly_d = stb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end

        rise          = stb_q & ~stb_dly_q;
        key_pulse_d   = '0;
        multi_press_d = 1'b0;
        // Only a lone press with nothing else held is forwarded; chords and rollover are flagged instead.
        if (rise != '0) begin
            if ($onehot(rise) && (stb_dly_q == '0)) begin
                key_pulse_d = rise;
            end else begin
                multi_press_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stb_q         <= '0;
            stb_dly_q     <= '0;
            key_pulse_q   <= '0;
            multi_press_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stb_q         <= stb_d;
            stb_dly_q     <= stb_dly_d;
            key_pulse_q   <= key_pulse_d;
            multi_press_q <= multi_press_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_level   = stb_q;
    assign key_pulse   = key_pulse_q;
    assign multi_press = multi_press_q;

endmodule

// File: doc/keypad_debounce_edge.md
Name: keypad_debounce_edge

Overview:
- Front-end stage of the doorlock path. Conditions raw mechanical keypad inputs (digits 0-9 plus star) into clean, single-cycle, one-hot press pulses.
- Per key: polarity normalisation, 2-FF synchronisation, counter-based debounce and rising-edge detection.
- A two-key lockout blocks pulses while any other key is held.
- Outputs feed the doorlock FSM button inputs directly: bit 10 = star, bits 9..0 = digits.

Parameters:
WIDTH, 11, number of key inputs (bits 9..0 digits, bit 10 star)
DB_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz); minimum 2
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES
IN_ACTIVE_LOW, 1, 1 = raw key pressed when input low; 0 = pressed when high

Ports:
clk  input  1  system clock, single clock domain
n_rst  input  1  asynchronous active-low reset
key_raw  input  WIDTH  raw asynchronous key inputs
key_level  output  WIDTH  debounced key level, active-high, 1 = held
key_pulse  output  WIDTH  one-cycle active-high press pulse, at most one bit set per cycle
multi_press  output  1  one-cycle pulse when a press is rejected by lockout

Behaviour:
- Reset (n_rst low, asynchronous): synchroniser FFs, stable levels, delayed levels, all counters, key_level, key_pulse and multi_press all go to 0. Normalised inactive = 0.
- Normalisation: norm = IN_ACTIVE_LOW ? ~key_raw : key_raw. Purely combinational ahead of the synchroniser.
- Synchroniser: two flops per bit, giving sync2.
- Debounce, per bit, with counter cnt and stable level stb:
  - sync2 == stb: cnt <= 0.
  - sync2 != stb and cnt == DB_CYCLES-1: stb <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any mismatch gap shorter than DB_CYCLES samples resets cnt, so no level change is accepted.
- key_level = stb, registered.
- Edge detect: stb_d <= stb each cycle; rise = stb & ~stb_d.
- Lockout, registered decision, outputs updated on the edge after the stb rise:
  - rise one-hot and stb_d == 0: key_pulse <= rise, multi_press <= 0.
  - rise != 0 otherwise (two or more keys rising together, or another key already held): key_pulse <= 0, multi_press <= 1.
  - rise == 0: key_pulse <= 0, multi_press <= 0.
- Releases (stb falling) never produce a pulse.
- A held key produces exactly one pulse. Re-press requires a debounced release first.
- Latency: new raw level sampled at edge 1 -> sync2 at edge 2 -> stb at edge 2+DB_CYCLES -> key_pulse high for the single cycle following edge 3+DB_CYCLES.
- Release latency on key_level is identical.
- Key held through reset deassertion: treated as a fresh press. It debounces from zero and pulses at edge 3+DB_CYCLES after reset release, subject to lockout.
- Reset asserted mid-debounce: count discarded, no pulse.
- Counter never exceeds DB_CYCLES-1; there is no wrap-around.

Test Plan (DB_CYCLES=4, IN_ACTIVE_LOW=1):
1. Clean press: key_raw[1] driven 1->0 before edge 1, held -> key_level[1]=1 from edge 6; key_pulse=11'h002 for exactly one cycle after edge 7; multi_press=0; no further pulses while held.
2. Bounce: key_raw[7] low 3 cycles, high 1 cycle, then low steady -> no pulse during bounce; single key_pulse=11'h080 exactly 7 edges after the final low begins.
3. Star then release/re-press: key_raw[10] pressed, released (debounced), pressed again -> two key_pulse=11'h400 pulses; no pulse on release; key_level[10] tracks with 6-edge latency.
4. Simultaneous press: key_raw[2] and key_raw[5] fall in the same cycle -> key_pulse stays 0; multi_press=1 for one cycle after edge 7.
5. Rollover lockout: key_raw[3] held (pulse 11'h008 emitted), then key_raw[4] pressed -> no key_pulse for bit 4; one multi_press pulse. After both released, key_raw[4] press -> key_pulse=11'h010.
6. Reset mid-debounce: key_raw[9] low, n_rst pulsed low at edge 3 -> all outputs 0 immediately. After release, key still held -> single key_pulse=11'h200 at edge 7 after reset release.
